// File: rtl/serial_mag_compare.sv
// Multi-cycle MSB-first magnitude comparator for the RGB status LEDs.
// Compares DIGIT bits per cycle and stops at the first differing slice.
module serial_mag_compare #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2,
  localparam int NSLICE = WIDTH / DIGIT,
  localparam int CW = $clog2(NSLICE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             red,
  output logic             green,
  output logic             blue,
  output logic [CW-1:0]    cycles,
  output logic [1:0]       state_dbg
);

  generate
    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_params
      $error("serial_mag_compare: WIDTH must be a multiple of DIGIT and >= DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] sa;
  logic [DIGIT-1:0] sb;

  assign sa        = opa[WIDTH-1 -: DIGIT];
  assign sb        = opb[WIDTH-1 -: DIGIT];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      red    <= 1'b0;
      green  <= 1'b0;
      blue   <= 1'b0;
      cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Flipping the sign bit maps two's complement order onto unsigned order.
            opa   <= a ^ (signed_mode ? MSB_MASK : '0);
            opb   <= b ^ (signed_mode ? MSB_MASK : '0);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (sa != sb) begin
            red    <= (sa > sb);
            green  <= (sa < sb);
            blue   <= 1'b1;
            cycles <= cnt + CW'(1);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else if (cnt == CW'(NSLICE - 1)) begin
            red    <= 1'b1;
            green  <= 1'b1;
            blue   <= 1'b0;
            cycles <= cnt + CW'(1);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            opa <= opa << DIGIT;
            opb <= opb << DIGIT;
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed bench for serial_mag_compare (WIDTH=8, DIGIT=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_mag_compare;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int CW    = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             red;
  logic             green;
  logic             blue;
  logic [CW-1:0]    cycles;
  logic [1:0]       state_dbg;

  int total;
  int bad;
  logic [5:0] exp_q[$];

  serial_mag_compare #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .red(red), .green(green),
    .blue(blue), .cycles(cycles), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One comparison: start pulse, count busy cycles until done, score the result.
  // inject pulses start with other operands during the first COMPARE cycle.
  task automatic do_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic sm, input int exp_n, input logic [5:0] exp_res,
                        input bit inject);
    int  nb;
    bit  seen;
    logic [5:0] e;
    nb = 0;
    seen = 0;
    exp_q.push_back(exp_res);
    @(negedge clk);
    start = 1'b1; a = va; b = vb; signed_mode = sm;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    signed_mode = 1'($urandom_range(0, 1));
    for (int i = 0; i < 20; i++) begin
      if (busy && done) check({tag, "_overlap"}, 1, 0);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nb++;
      if (inject && i == 0) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_latency"}, nb, exp_n);
    e = exp_q.pop_front();
    check({tag, "_result"}, {26'd0, red, green, blue, cycles}, {26'd0, e});
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {26'd0, busy, done, red, green, blue, cycles}, 0);
    check("reset_state", state_dbg, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // result packing: {red, green, blue, cycles}
    do_cmp("t1_unsigned_gt", 8'hC0, 8'h40, 1'b0, 1, {3'b101, 3'd1}, 0);
    do_cmp("t2_equal_u",     8'h5A, 8'h5A, 1'b0, 4, {3'b110, 3'd4}, 0);
    do_cmp("t2_equal_s",     8'h5A, 8'h5A, 1'b1, 4, {3'b110, 3'd4}, 0);
    do_cmp("t3_signed",      8'h80, 8'h01, 1'b1, 1, {3'b011, 3'd1}, 0);
    do_cmp("t3_unsigned",    8'h80, 8'h01, 1'b0, 1, {3'b101, 3'd1}, 0);
    do_cmp("t4_lsb_slice",   8'h12, 8'h13, 1'b0, 4, {3'b011, 3'd4}, 0);
    do_cmp("mid_slice",      8'h34, 8'h38, 1'b0, 3, {3'b011, 3'd3}, 0);
    do_cmp("signed_neg_pos", 8'hF0, 8'h0F, 1'b1, 1, {3'b011, 3'd1}, 0);
    do_cmp("signed_neg_neg", 8'hFE, 8'hFD, 1'b1, 4, {3'b101, 3'd4}, 0);
    do_cmp("t5_ignored",     8'h12, 8'h13, 1'b0, 4, {3'b011, 3'd4}, 1);

    // abort mid-COMPARE with reset
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h13; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", {26'd0, busy, done, red, green, blue, cycles}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) check("abort_no_activity", {30'd0, busy, done}, 0);
    end
    check("abort_idle", state_dbg, 0);

    // start held high: one comparison every 3 cycles
    start = 1'b1; a = 8'hC0; b = 8'h40; signed_mode = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check($sformatf("held_done_%0d", i), done, (i % 3 == 2) ? 1 : 0);
      check($sformatf("held_busy_%0d", i), busy, (i % 3 == 1) ? 1 : 0);
      if (i >= 2)
        check($sformatf("held_res_%0d", i), {26'd0, red, green, blue, cycles}, {26'd0, 3'b101, 3'd1});
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
